// File: rtl/usbh_pkg.sv
// Shared constants and types for the usbh packet FIFO family.
package usbh_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;

  // Pointers carry one extra MSB so full and empty stay distinguishable.
  function automatic int ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction

  localparam int DEF_PTR_W = ptr_w(DEF_ADDR_W);

  typedef logic [DEF_PTR_W-1:0] cnt_t;

endpackage

// File: rtl/usbh_pkt_fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read, contents not reset.
module usbh_pkt_fifo_ram #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/usbh_pkt_fifo.sv
// Packet-aware sync FIFO: writer stages words then commits or rolls back; reader sees committed data only.
// Optional sticky overflow/underflow outputs are enabled by defining USBH_PKT_FIFO_ERR_EN.
module usbh_pkt_fifo
  import usbh_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WIDTH-1:0]  data_i,
  input  logic              push_i,
  input  logic              commit_i,
  input  logic              rollback_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [WIDTH-1:0]  data_o,
  output logic [ADDR_W:0]   level_o,
  output logic [ADDR_W:0]   staged_o
`ifdef USBH_PKT_FIFO_ERR_EN
  ,
  output logic              overflow_o,
  output logic              underflow_o
`endif
);

  localparam int PW = ptr_w(ADDR_W);
  localparam logic [PW-1:0] DEPTH_CNT = PW'(DEPTH);

  logic [PW-1:0] rd_ptr, cm_ptr, wr_ptr;
  logic [PW-1:0] wr_ptr_next;
  logic [PW-1:0] used;
  logic          push_ok, pop_ok, ram_we;

  assign used     = wr_ptr - rd_ptr;
  assign full_o   = (used == DEPTH_CNT);
  assign empty_o  = (rd_ptr == cm_ptr);
  assign level_o  = cm_ptr - rd_ptr;
  assign staged_o = wr_ptr - cm_ptr;

  assign push_ok     = push_i & ~full_o;
  assign pop_ok      = pop_i & ~empty_o;
  assign wr_ptr_next = wr_ptr + PW'(push_ok);
  // A word pushed alongside flush or rollback would never become visible, so skip the write.
  assign ram_we      = push_ok & ~flush_i & ~rollback_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      cm_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      cm_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      if (rollback_i) begin
        wr_ptr <= cm_ptr;
      end else begin
        wr_ptr <= wr_ptr_next;
        if (commit_i) cm_ptr <= wr_ptr_next;
      end
    end
  end

  usbh_pkt_fifo_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i (clk_i),
    .we    (ram_we),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (data_i),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (data_o)
  );

`ifdef USBH_PKT_FIFO_ERR_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (flush_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (push_i & full_o)  overflow_o  <= 1'b1;
      if (pop_i  & empty_o) underflow_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_usbh_pkt_fifo.sv
// Directed self-checking bench for usbh_pkt_fifo (default 8 x 64 configuration).
module tb_usbh_pkt_fifo;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] data_i = '0;
  logic       push_i = 1'b0, commit_i = 1'b0, rollback_i = 1'b0, pop_i = 1'b0, flush_i = 1'b0;
  logic       full_o, empty_o;
  logic [7:0] data_o;
  logic [6:0] level_o, staged_o;
`ifdef USBH_PKT_FIFO_ERR_EN
  logic       overflow_o, underflow_o;
`endif

  int total = 0;
  int bad   = 0;
  bit seen_full;

  always #5 clk_i = ~clk_i;

  usbh_pkt_fifo #(.WIDTH(8), .DEPTH(64), .ADDR_W(6)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .push_i     (push_i),
    .commit_i   (commit_i),
    .rollback_i (rollback_i),
    .pop_i      (pop_i),
    .flush_i    (flush_i),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .data_o     (data_o),
    .level_o    (level_o),
    .staged_o   (staged_o)
`ifdef USBH_PKT_FIFO_ERR_EN
    ,
    .overflow_o (overflow_o),
    .underflow_o(underflow_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; outputs are stable 1 time unit after the edge.
  task automatic cyc(input logic push, input logic [7:0] d, input logic commit,
                     input logic rollback, input logic pop, input logic flush);
    push_i = push; data_i = d; commit_i = commit;
    rollback_i = rollback; pop_i = pop; flush_i = flush;
    @(posedge clk_i);
    #1;
    push_i = 1'b0; commit_i = 1'b0; rollback_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0;
    if (full_o) seen_full = 1'b1;
    $display("txn t=%0t push=%0b d=%02h cm=%0b rb=%0b pop=%0b fl=%0b -> lvl=%0d stg=%0d e=%0b f=%0b q=%02h",
             $time, push, d, commit, rollback, pop, flush, level_o, staged_o, empty_o, full_o, data_o);
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_staged", 32'(staged_o), 32'd0);

    // Stage three words, then commit.
    cyc(1, 8'h11, 0, 0, 0, 0);
    cyc(1, 8'h22, 0, 0, 0, 0);
    cyc(1, 8'h33, 0, 0, 0, 0);
    chk("stage_empty", 32'(empty_o), 32'd1);
    chk("stage_staged", 32'(staged_o), 32'd3);
    chk("stage_level", 32'(level_o), 32'd0);
    cyc(0, 8'h00, 1, 0, 0, 0);
    chk("cm_empty", 32'(empty_o), 32'd0);
    chk("cm_data", 32'(data_o), 32'h11);
    chk("cm_level", 32'(level_o), 32'd3);
    chk("cm_staged", 32'(staged_o), 32'd0);
    cyc(0, 8'h00, 0, 0, 1, 0);
    chk("pop1_data", 32'(data_o), 32'h22);
    cyc(0, 8'h00, 0, 0, 1, 0);
    chk("pop2_data", 32'(data_o), 32'h33);
    cyc(0, 8'h00, 0, 0, 1, 0);
    chk("pop3_empty", 32'(empty_o), 32'd1);

    // Rollback discards staged words plus a same-cycle push.
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'hA0 + i), 0, 0, 0, 0);
    chk("rb_pre_staged", 32'(staged_o), 32'd5);
    cyc(1, 8'hA5, 0, 1, 0, 0);
    chk("rb_staged", 32'(staged_o), 32'd0);
    chk("rb_empty", 32'(empty_o), 32'd1);
    cyc(1, 8'h5A, 1, 0, 0, 0);
    chk("pushcm_level", 32'(level_o), 32'd1);
    chk("pushcm_data", 32'(data_o), 32'h5A);
    cyc(0, 8'h00, 0, 0, 1, 0);
    chk("pushcm_empty", 32'(empty_o), 32'd1);

    // Fill completely, overflow, push+pop while full, drain, underflow.
    for (int i = 0; i < 64; i++) cyc(1, 8'(i), (i == 63), 0, 0, 0);
    chk("fill_full", 32'(full_o), 32'd1);
    chk("fill_level", 32'(level_o), 32'd64);
    cyc(1, 8'hFF, 1, 0, 0, 0);
    chk("ovf_level", 32'(level_o), 32'd64);
    chk("ovf_staged", 32'(staged_o), 32'd0);
    chk("ovf_data", 32'(data_o), 32'h00);
`ifdef USBH_PKT_FIFO_ERR_EN
    chk("ovf_flag", 32'(overflow_o), 32'd1);
    chk("ovf_no_unf", 32'(underflow_o), 32'd0);
`endif
    cyc(1, 8'hEE, 1, 0, 1, 0);
    chk("fullpp_level", 32'(level_o), 32'd63);
    chk("fullpp_staged", 32'(staged_o), 32'd0);
    chk("fullpp_full", 32'(full_o), 32'd0);
    for (int i = 1; i < 64; i++) begin
      chk($sformatf("drain_%0d", i), 32'(data_o), 32'(i));
      cyc(0, 8'h00, 0, 0, 1, 0);
    end
    chk("drain_empty", 32'(empty_o), 32'd1);
    cyc(0, 8'h00, 0, 0, 1, 0);
    chk("unf_level", 32'(level_o), 32'd0);
    chk("unf_empty", 32'(empty_o), 32'd1);
`ifdef USBH_PKT_FIFO_ERR_EN
    chk("unf_flag", 32'(underflow_o), 32'd1);
`endif

    // Wrap: pointers start at 68, cross index 63->0 and pointer 127->0.
    seen_full = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 40; k++) cyc(1, 8'(r * 40 + k), (k == 39), 0, 0, 0);
      chk($sformatf("wrap_lvl_%0d", r), 32'(level_o), 32'd40);
      for (int k = 0; k < 40; k++) begin
        chk($sformatf("wrap_%0d_%0d", r, k), 32'(data_o), 32'(r * 40 + k));
        cyc(0, 8'h00, 0, 0, 1, 0);
      end
      chk($sformatf("wrap_empty_%0d", r), 32'(empty_o), 32'd1);
    end
    chk("wrap_never_full", 32'(seen_full), 32'd0);

    // Flush beats a simultaneous push and pop.
    for (int i = 0; i < 10; i++) cyc(1, 8'(8'hC0 + i), (i == 9), 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'hD0 + i), 0, 0, 0, 0);
    chk("prefl_level", 32'(level_o), 32'd10);
    chk("prefl_staged", 32'(staged_o), 32'd5);
    cyc(1, 8'h77, 1, 0, 1, 1);
    chk("fl_level", 32'(level_o), 32'd0);
    chk("fl_staged", 32'(staged_o), 32'd0);
    chk("fl_empty", 32'(empty_o), 32'd1);
    chk("fl_full", 32'(full_o), 32'd0);
`ifdef USBH_PKT_FIFO_ERR_EN
    chk("fl_ovf_clr", 32'(overflow_o), 32'd0);
    chk("fl_unf_clr", 32'(underflow_o), 32'd0);
`endif

    // Asynchronous reset mid-packet, checked before the next edge.
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'hE0 + i), (i == 2), 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(1, 8'(8'hF0 + i), 0, 0, 0, 0);
    chk("prerst_level", 32'(level_o), 32'd3);
    chk("prerst_staged", 32'(staged_o), 32'd7);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_empty", 32'(empty_o), 32'd1);
    chk("arst_full", 32'(full_o), 32'd0);
    chk("arst_level", 32'(level_o), 32'd0);
    chk("arst_staged", 32'(staged_o), 32'd0);
    #2 rst_i = 1'b0;
    cyc(1, 8'h42, 1, 0, 0, 0);
    chk("postrst_data", 32'(data_o), 32'h42);
    chk("postrst_level", 32'(level_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usbh_pkt_fifo.md
Name: usbh_pkt_fifo

Overview:
- Parametrised packet-aware sync FIFO; successor to the USB host byte FIFO.
- Write side stages a packet, then commits or rolls it back (e.g. discard an RX packet on CRC/PID error). Read side sees committed data only, first-word-fall-through.
- Sits between usbh SIE RX/TX paths and the register/AXI interface; one instance per direction.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 64, entries; must equal 2**ADDR_W.
- ADDR_W, 6, address width; pointers are ADDR_W+1 bits.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; asynchronous, active-high.
- data_i  input  WIDTH  write data.
- push_i  input  1  write data_i at wr_ptr.
- commit_i  input  1  publish all staged words, including a push in the same cycle.
- rollback_i  input  1  discard all staged words, including a push in the same cycle.
- pop_i  input  1  consume word at head.
- flush_i  input  1  clear FIFO.
- full_o  output  1  no free entry (staged + committed == DEPTH).
- empty_o  output  1  no committed word available.
- data_o  output  WIDTH  head word; valid when empty_o=0.
- level_o  output  ADDR_W+1  committed words available (0..DEPTH).
- staged_o  output  ADDR_W+1  uncommitted words (0..DEPTH).

Behaviour:
- Pointers: rd_ptr, cm_ptr (commit), wr_ptr, each ADDR_W+1 bits, wrapping mod 2*DEPTH. Memory index is the low ADDR_W bits.
- Reset (async assert, sync release): all pointers 0; empty_o=1, full_o=0, level_o=0, staged_o=0. data_o is don't-care.
- Derived outputs: empty_o = (rd_ptr==cm_ptr). full_o = (wr_ptr-rd_ptr)==DEPTH. level_o = cm_ptr-rd_ptr. staged_o = wr_ptr-cm_ptr. All are registered-pointer functions, so no comb path from inputs.
- Push: accepted iff push_i & !full_o. Memory written and wr_ptr+1 on the clock edge. Push while full is dropped; pointers unchanged.
- Pop: accepted iff pop_i & !empty_o. rd_ptr+1. Pop while empty is ignored.
- data_o: async read of mem[rd_ptr]. The new head appears in the cycle after a pop.
- Commit: cm_ptr <= wr_ptr_next, i.e. includes an accepted same-cycle push. Word is visible (empty_o=0) the cycle after commit. Commit with nothing staged is a no-op.
- Rollback: wr_ptr <= cm_ptr; a same-cycle push is discarded. Rollback has priority over commit when both are asserted.
- Simultaneous push and pop are both accepted. With full_o=1 and a pop, the push is still dropped (full evaluated on current state).
- Pop never touches staged words. Readers can drain a committed packet while the next packet is staged.
- Flush: highest priority. All pointers <= 0 next cycle; push/pop/commit/rollback in the same cycle are ignored.
- Wrap-around: pointer MSB distinguishes full from empty. Sequences crossing index DEPTH-1 -> 0 must behave identically.
- A staged packet may fill the FIFO: full_o=1 with level_o=0. The writer must commit or rollback; no deadlock check in RTL.

Optional Feature:
- USBH_PKT_FIFO_ERR_EN defined: adds outputs overflow_o and underflow_o (1 bit each).
  - Sticky: set on a dropped push (push_i & full_o) or an ignored pop (pop_i & empty_o).
  - Cleared by flush_i or reset; set has priority over clear only when not flushing.
- Undefined: ports absent; dropped push/pop are silent.

Decomposition:
- Shared package usbh_pkg: pointer-width helper constant, default WIDTH/DEPTH, and a typedef for the level/count type.
- One natural sub-module, usbh_pkt_fifo_ram: DEPTH x WIDTH, sync write, async read, no reset on contents. It maps to distributed RAM.
- Pointer and flag logic stays in the top.

Test Plan:
- Push 0x11,0x22,0x33 with no commit -> empty_o=1, staged_o=3. Commit -> next cycle empty_o=0, data_o=0x11, level_o=3, staged_o=0.
- Push 0xA0..0xA4, rollback with push 0xA5 in the same cycle -> staged_o=0, empty_o=1. Then push 0x5A with commit same cycle -> pop returns 0x5A.
- Push 64 words and commit -> full_o=1, level_o=64. Extra push 0xFF is dropped (ERR_EN: overflow_o=1). Pop all 64 in order -> empty_o=1; extra pop ignored (underflow_o=1).
- Wrap: repeat commit 40 / pop 40 three times -> data order preserved across index 63->0; full_o never 1.
- Commit 10 words, stage 5, assert flush_i together with push and pop -> next cycle level_o=0, staged_o=0, empty_o=1, full_o=0.
- Assert rst_i mid-packet (staged 7, committed 3) asynchronously between edges -> outputs at reset values immediately, before the next clock edge.
